// File: rtl/mio_bus_responder_if.sv
// CPU_MIO request/response bundle between the multicycle controller (master)
// and the memory/IO responder (slave).
interface mio_bus_responder_if;
  logic        cpu_mio;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        MIO_ready;
  logic        bus_err;

  modport master (
    output cpu_mio, mem_r, mem_w, addr_bus, data_out,
    input  data_in, MIO_ready, bus_err
  );

  modport slave (
    input  cpu_mio, mem_r, mem_w, addr_bus, data_out,
    output data_in, MIO_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes CPU_MIO requests onto data RAM, LED register,
// switches and counter/keyboard, returns data with a one-cycle MIO_ready.
module mio_bus_responder #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_responder_if.slave bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [31:0]       led,
  input  logic [15:0]       sw,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              kbd_ack,
  output logic              INT_CNT,
  output logic              INT_KBD
);

  typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WAIT, PERIPH, DONE} state_t;
  typedef enum logic [2:0] {T_RAM, T_LED, T_SW, T_CNT, T_KBD, T_NONE} tgt_t;

  state_t            state_r;
  logic              rd_r;
  logic              wr_r;
  logic [3:0]        region_r;
  logic [1:0]        sel_r;
  logic [31:0]       wdata_r;
  logic [2:0]        wait_r;
  logic              err_r;
  logic [31:0]       data_in_r;
  logic              mio_ready_r;
  logic              bus_err_r;
  logic              ram_en_r;
  logic              ram_we_r;
  logic [RAM_AW-1:0] ram_addr_r;
  logic [31:0]       ram_din_r;
  logic [31:0]       led_r;
  logic [31:0]       cnt_r;
  logic              int_cnt_r;
  logic              int_kbd_r;
  logic              kbd_ack_r;

  tgt_t              tgt_s;
  logic              err_s;
  logic              periph_wr_s;
  logic              cnt_wr_s;
  logic [31:0]       rdata_s;

  assign bus.data_in   = data_in_r;
  assign bus.MIO_ready = mio_ready_r;
  assign bus.bus_err   = bus_err_r;
  assign ram_en        = ram_en_r;
  assign ram_we        = ram_we_r;
  assign ram_addr      = ram_addr_r;
  assign ram_din       = ram_din_r;
  assign led           = led_r;
  assign kbd_ack       = kbd_ack_r;
  assign INT_CNT       = int_cnt_r;
  assign INT_KBD       = int_kbd_r;

  // Target decode from the latched request address.
  always_comb begin
    tgt_s = T_NONE;
    case (region_r)
      4'h0: tgt_s = T_RAM;
      4'hE: tgt_s = T_LED;
      4'hF: begin
        case (sel_r)
          2'b00:   tgt_s = T_SW;
          2'b01:   tgt_s = T_CNT;
          2'b10:   tgt_s = T_KBD;
          default: tgt_s = T_NONE;
        endcase
      end
      default: tgt_s = T_NONE;
    endcase
  end

  // Error, peripheral write strobes and read-data mux for the PERIPH state.
  // A RAM target only reaches PERIPH when read and write were both requested.
  always_comb begin
    err_s = (rd_r & wr_r) | (tgt_s == T_NONE) | (tgt_s == T_RAM) |
            (wr_r & ((tgt_s == T_SW) | (tgt_s == T_KBD)));
    periph_wr_s = (state_r == PERIPH) & wr_r & ~err_s;
    cnt_wr_s    = periph_wr_s & (tgt_s == T_CNT);
    rdata_s     = 32'h0000_0000;
    case (tgt_s)
      T_LED:   rdata_s = led_r;
      T_SW:    rdata_s = {16'h0000, sw};
      T_CNT:   rdata_s = cnt_r;
      T_KBD:   rdata_s = {23'h00_0000, kbd_valid, kbd_data};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // Request FSM with all bus, RAM, LED and keyboard-ack outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
      region_r    <= 4'h0;
      sel_r       <= 2'b00;
      wdata_r     <= 32'h0000_0000;
      wait_r      <= 3'd0;
      err_r       <= 1'b0;
      data_in_r   <= 32'h0000_0000;
      mio_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_din_r   <= 32'h0000_0000;
      led_r       <= 32'h0000_0000;
      kbd_ack_r   <= 1'b0;
    end else begin
      mio_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_din_r   <= 32'h0000_0000;
      kbd_ack_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cpu_mio && (bus.mem_r || bus.mem_w)) begin
            rd_r     <= bus.mem_r;
            wr_r     <= bus.mem_w;
            region_r <= bus.addr_bus[31:28];
            sel_r    <= bus.addr_bus[3:2];
            wdata_r  <= bus.data_out;
            if ((bus.addr_bus[31:28] == 4'h0) && !(bus.mem_r && bus.mem_w)) begin
              ram_en_r   <= 1'b1;
              ram_we_r   <= bus.mem_w;
              ram_addr_r <= bus.addr_bus[RAM_AW+1:2];
              ram_din_r  <= bus.data_out;
              state_r    <= RAM_ACC;
            end else begin
              state_r <= PERIPH;
            end
          end
        end
        RAM_ACC: begin
          wait_r  <= 3'(RAM_LAT);
          err_r   <= 1'b0;
          state_r <= RAM_WAIT;
        end
        RAM_WAIT: begin
          if (wait_r <= 3'd1) begin
            if (rd_r) begin
              data_in_r <= ram_dout;
            end
            state_r <= DONE;
          end else begin
            wait_r <= wait_r - 3'd1;
          end
        end
        PERIPH: begin
          err_r <= err_s;
          if (err_s) begin
            data_in_r <= 32'h0000_0000;
          end else if (rd_r) begin
            data_in_r <= rdata_s;
          end
          if (periph_wr_s && (tgt_s == T_LED)) begin
            led_r <= wdata_r;
          end
          if (rd_r && !err_s && (tgt_s == T_KBD)) begin
            kbd_ack_r <= kbd_valid;
          end
          state_r <= DONE;
        end
        DONE: begin
          mio_ready_r <= 1'b1;
          bus_err_r   <= err_r;
          state_r     <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Down-counter; a bus write in the same edge as the 1->0 step takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= 32'h0000_0000;
      int_cnt_r <= 1'b0;
    end else if (cnt_wr_s) begin
      cnt_r     <= wdata_r;
      int_cnt_r <= 1'b0;
    end else if (cnt_r != 32'h0000_0000) begin
      cnt_r <= cnt_r - 32'h0000_0001;
      if (cnt_r == 32'h0000_0001) begin
        int_cnt_r <= 1'b1;
      end
    end
  end

  // Keyboard interrupt level follows kbd_valid one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_kbd_r <= 1'b0;
    end else begin
      int_kbd_r <= kbd_valid;
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: vector table plus hand-written
// sequences for counter, keyboard and mid-transaction reset.
module tb_mio_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- main DUT (RAM_LAT=1) ----------------
  logic        reset;
  logic        ram_en, ram_we, kbd_ack, int_cnt, int_kbd;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout, led;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic [31:0] mem [0:1023];

  mio_bus_responder_if bus();

  mio_bus_responder #(.RAM_AW(10), .RAM_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .led(led), .sw(16'h1234), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .kbd_ack(kbd_ack), .INT_CNT(int_cnt), .INT_KBD(int_kbd)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  int ack_cnt = 0;
  always @(negedge clk) if (kbd_ack) ack_cnt++;

  // ---------------- second DUT (RAM_LAT=4) ----------------
  logic        reset4;
  logic        ram_en4, ram_we4, kbd_ack4, int_cnt4, int_kbd4;
  logic [9:0]  ram_addr4;
  logic [31:0] ram_din4, ram_dout4, led4;

  mio_bus_responder_if bus4();

  mio_bus_responder #(.RAM_AW(10), .RAM_LAT(4)) dut4 (
    .clk(clk), .reset(reset4), .bus(bus4),
    .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_din(ram_din4),
    .ram_dout(ram_dout4), .led(led4), .sw(16'h0000), .kbd_valid(1'b0),
    .kbd_data(8'h00), .kbd_ack(kbd_ack4), .INT_CNT(int_cnt4), .INT_KBD(int_kbd4)
  );

  initial ram_dout4 = 32'h0;
  always @(posedge clk) if (ram_en4) ram_dout4 <= {16'hCAFE, 6'b0, ram_addr4};

  int ready4_cnt = 0;
  always @(negedge clk) if (bus4.MIO_ready) ready4_cnt++;

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit s, input logic c, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (s) begin
      bus4.cpu_mio = c; bus4.mem_r = r; bus4.mem_w = w; bus4.addr_bus = a; bus4.data_out = d;
    end else begin
      bus.cpu_mio = c; bus.mem_r = r; bus.mem_w = w; bus.addr_bus = a; bus.data_out = d;
    end
  endtask

  // Present a request, return #1 after the accepting edge with the bus scrambled.
  task automatic issue(input bit s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(s, 1'b1, r, w, a, d);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 1'b0, 1'b0, 32'hBAD0_0F00, 32'h5A5A_5A5A);
  endtask

  // Wait for MIO_ready; lat counts edges after the accepting edge.
  task automatic finish(input bit s, input int start, output int lat,
                        output logic [31:0] d, output logic e);
    logic rdy;
    lat = -1;
    d   = 32'hX;
    e   = 1'bX;
    for (int i = start + 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      rdy = s ? bus4.MIO_ready : bus.MIO_ready;
      if (rdy) begin
        lat = i;
        d   = s ? bus4.data_in : bus.data_in;
        e   = s ? bus4.bus_err : bus.bus_err;
        break;
      end
    end
    if (lat < 0) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      rdy = s ? bus4.MIO_ready : bus.MIO_ready;
      check("ready_single_cycle", {31'b0, rdy}, 32'd0);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
    logic [31:0] led;
  } vec_t;

  vec_t vt [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic        e;
    int          snap;

    vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_1010, 32'h0,         3, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         3, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vt[5]  = '{1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 2, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_00A5};
    vt[6]  = '{1'b1, 1'b0, 32'hE000_0FF0, 32'h0,         2, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
    vt[7]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0,         2, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_00A5};
    vt[8]  = '{1'b1, 1'b0, 32'h5000_0000, 32'h0,         2, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_00A5};
    vt[9]  = '{1'b1, 1'b0, 32'hE000_0000, 32'h0,         2, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
    vt[10] = '{1'b1, 1'b1, 32'hE000_0000, 32'h0000_0077, 2, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_00A5};
    vt[11] = '{1'b0, 1'b1, 32'hF000_0000, 32'h0000_0001, 2, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_00A5};
    vt[12] = '{1'b0, 1'b1, 32'hF000_0008, 32'h0000_0001, 2, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_00A5};
    vt[13] = '{1'b1, 1'b0, 32'hE000_0000, 32'h0,         2, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
    vt[14] = '{1'b1, 1'b0, 32'hF000_000C, 32'h0,         2, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_00A5};

    reset     = 1'b1;
    reset4    = 1'b1;
    kbd_valid = 1'b0;
    kbd_data  = 8'h1C;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycles(3);
    check("reset_data_in", bus.data_in, 32'h0);
    check("reset_led", led, 32'h0);
    check("reset_flags", {25'b0, bus.MIO_ready, bus.bus_err, ram_en, ram_we, kbd_ack, int_cnt, int_kbd}, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    reset4 = 1'b0;

    // RAM write strobe shape.
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("ram_strobe", {30'b0, ram_en, ram_we}, 32'h3);
    check("ram_addr", {22'b0, ram_addr}, 32'h4);
    check("ram_din", ram_din, 32'hDEAD_BEEF);
    cycles(1);
    check("ram_en_one_cycle", {31'b0, ram_en}, 32'h0);
    finish(1'b0, 1, lat, d, e);
    check("ram_write_latency", lat, 32'd3);

    // Table of single transactions.
    for (int i = 0; i < 15; i++) begin
      issue(1'b0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
      finish(1'b0, 0, lat, d, e);
      check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      if (vt[i].chk_data) check($sformatf("vec%0d_data", i), d, vt[i].data);
      check($sformatf("vec%0d_bus_err", i), {31'b0, e}, {31'b0, vt[i].err});
      check($sformatf("vec%0d_led", i), led, vt[i].led);
    end

    // Counter read value while running: loaded 100, read three edges later.
    issue(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'd100);
    finish(1'b0, 0, lat, d, e);
    issue(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'h0);
    finish(1'b0, 0, lat, d, e);
    check("cnt_read", d, 32'd97);

    // Counter load 3: interrupt three cycles after load edge, then held.
    issue(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'd3);
    cycles(3);
    check("int_cnt_before", {31'b0, int_cnt}, 32'h0);
    cycles(1);
    check("int_cnt_set", {31'b0, int_cnt}, 32'h1);
    cycles(5);
    check("int_cnt_held", {31'b0, int_cnt}, 32'h1);

    // Write lands on the 1->0 edge: write wins.
    issue(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'd3);
    cycles(2);
    issue(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'd5);
    cycles(1);
    check("int_cnt_collision", {31'b0, int_cnt}, 32'h0);
    cycles(4);
    check("int_cnt_reload_pending", {31'b0, int_cnt}, 32'h0);
    cycles(1);
    check("int_cnt_reload_fire", {31'b0, int_cnt}, 32'h1);

    // Writing 0 clears and keeps interrupt low.
    issue(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'd0);
    cycles(2);
    check("int_cnt_clear", {31'b0, int_cnt}, 32'h0);
    cycles(5);
    check("int_cnt_stays_low", {31'b0, int_cnt}, 32'h0);

    // Keyboard read with a byte pending, then with none.
    @(negedge clk);
    kbd_valid = 1'b1;
    cycles(2);
    check("int_kbd_high", {31'b0, int_kbd}, 32'h1);
    snap = ack_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'hF000_0008, 32'h0);
    finish(1'b0, 0, lat, d, e);
    check("kbd_data", d, 32'h0000_011C);
    check("kbd_err", {31'b0, e}, 32'h0);
    check("kbd_ack_once", ack_cnt - snap, 32'd1);
    @(negedge clk);
    kbd_valid = 1'b0;
    cycles(2);
    check("int_kbd_low", {31'b0, int_kbd}, 32'h0);
    snap = ack_cnt;
    issue(1'b0, 1'b1, 1'b0, 32'hF000_0008, 32'h0);
    finish(1'b0, 0, lat, d, e);
    check("kbd_data_empty", d, 32'h0000_001C);
    check("kbd_no_ack", ack_cnt - snap, 32'd0);

    // RAM_LAT=4: normal read, then reset during RAM_WAIT, then recovery.
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    finish(1'b1, 0, lat, d, e);
    check("lat4_latency", lat, 32'd6);
    check("lat4_data", d, 32'hCAFE_0010);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    cycles(2);
    reset4 = 1'b1;
    cycles(1);
    check("abort_data_in", bus4.data_in, 32'h0);
    check("abort_flags", {25'b0, bus4.MIO_ready, bus4.bus_err, ram_en4, ram_we4, kbd_ack4, int_cnt4, int_kbd4}, 32'h0);
    check("abort_led", led4, 32'h0);
    reset4 = 1'b0;
    snap = ready4_cnt;
    cycles(10);
    check("abort_no_ready", ready4_cnt - snap, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    finish(1'b1, 0, lat, d, e);
    check("recover_latency", lat, 32'd6);
    check("recover_data", d, 32'hCAFE_0008);
    check("recover_err", {31'b0, e}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO responder at the far end of the CPU's CPU_MIO request interface.
- Decodes each read/write request from the multicycle controller and services it from one of four targets: synchronous data RAM, LED register, switch inputs, or the counter/keyboard peripheral.
- Returns data and a one-cycle MIO_ready completion.
- Sources the INT_CNT and INT_KBD interrupt levels consumed by the controller.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW 32-bit words).
- RAM_LAT, 1, RAM read/write latency in cycles, 1..7.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mio  in  1  request valid.
- mem_r  in  1  read request.
- mem_w  in  1  write request.
- addr_bus  in  32  byte address.
- data_out  in  32  write data from CPU.
- data_in  out  32  read data to CPU.
- MIO_ready  out  1  completion pulse.
- bus_err  out  1  error pulse, coincident with MIO_ready.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data.
- led  out  32  LED register.
- sw  in  16  switch inputs.
- kbd_valid  in  1  keyboard byte available.
- kbd_data  in  8  keyboard byte.
- kbd_ack  out  1  keyboard pop pulse.
- INT_CNT  out  1  counter interrupt level.
- INT_KBD  out  1  keyboard interrupt level.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; counter 0; state IDLE. Reset mid-transaction aborts it: no MIO_ready, no RAM/register side effects after the reset edge.
- Request accepted in IDLE when cpu_mio=1 and (mem_r|mem_w)=1. addr_bus, data_out, mem_r and mem_w are latched at the accepting edge k. Inputs are ignored afterwards until completion.
- Decode on latched addr[31:28]:
  - 0x0: RAM, word index addr[RAM_AW+1:2].
  - 0xE: LED register (any low bits).
  - 0xF, addr[3:2]=00: switches, read-only.
  - 0xF, addr[3:2]=01: counter.
  - 0xF, addr[3:2]=10: keyboard, read-only.
  - Anything else: unmapped.
- States: IDLE, RAM_ACC, RAM_WAIT, PERIPH, DONE.
- RAM path:
  - IDLE→RAM_ACC: ram_en=1, ram_we=mem_w, ram_addr and ram_din driven for exactly one cycle.
  - RAM_ACC→RAM_WAIT: wait counter loaded with RAM_LAT, decremented each cycle.
  - On the edge where it reaches 0 (edge k+RAM_LAT+1): read captures ram_dout into data_in; state→DONE.
- Peripheral/unmapped path: IDLE→PERIPH→DONE. The side effect and data capture occur at edge k+1.
- DONE: MIO_ready=1 for exactly one cycle (plus bus_err if flagged), then IDLE. An accept is possible from IDLE on the next edge (back-to-back).
- Latency:
  - RAM: MIO_ready high in the cycle following edge k+RAM_LAT+2.
  - Peripheral: high in the cycle following edge k+2.
- data_in holds its last captured value until the next read completion. Writes do not change data_in.
- mem_r=mem_w=1 together, unmapped address, or write to a read-only target: no side effect, read data 0, bus_err=1 with MIO_ready.
- Request dropped mid-transaction: transaction still completes, writes still commit, MIO_ready still pulses once.
- LED: write loads led=data_out; read returns led.
- Switches: read returns {16'b0, sw}.
- Counter:
  - Write loads the value and clears INT_CNT in the same edge.
  - Otherwise, if value≠0, it decrements by 1 each cycle. On the decrement 1→0, INT_CNT is set.
  - Holds at 0; INT_CNT stays 1 until the next counter write.
  - Read returns the current value.
  - A write in the same cycle as 1→0 wins (INT_CNT stays 0).
- Keyboard:
  - INT_KBD = kbd_valid, registered (1 cycle delay).
  - Read returns {23'b0, kbd_valid, kbd_data} sampled at edge k+1.
  - kbd_ack pulses 1 cycle (cycle after edge k+1) only if kbd_valid was 1 at that edge.

Test Plan:
- RAM_LAT=1; write 0x00000010 ← 0xDEADBEEF; read it back. Required: ram_addr=4 and ram_we=1 for one cycle; MIO_ready one cycle, 3 cycles after accept; read returns data_in=0xDEADBEEF, bus_err=0.
- Write 0xE0000000 ← 0x000000A5, then read it. Required: led=0x000000A5 after edge k+1; MIO_ready at cycle k+2; read returns 0x000000A5.
- Write counter 0xF0000004 ← 3. Required: INT_CNT=1 three cycles after the load edge and held. Second write of 0 clears INT_CNT, which stays low.
- kbd_valid=1, kbd_data=0x1C, read 0xF0000008. Required: data_in=0x0000011C, kbd_ack pulses once, INT_KBD=1 beforehand.
- Read 0x50000000, and separately issue mem_r=mem_w=1 to 0xE0000000. Required: data_in=0, bus_err=MIO_ready=1 for one cycle, led unchanged.
- Assert reset during RAM_WAIT (RAM_LAT=4). Required: no MIO_ready, all outputs 0 next cycle. A new request afterward completes normally.
